// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver.
// Raw ps2_clk/ps2_data are double-flopped, ps2_clk is glitch filtered, and
// 11-bit frames (start, 8 data LSB first, odd parity, stop) are deserialised.
// Good bytes update rx_byte and the 16-bit keycode history; bad frames raise
// one-cycle error strobes. Stalled frames are aborted after TIMEOUT_CYC cycles.
// Optional feature macro: PS2_RX_ERRCNT_EN (saturating error counter on err_count).
module ps2_frame_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic [7:0]  rx_byte,
  output logic        byte_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  localparam int FW = (FILTER_LEN  > 1) ? $clog2(FILTER_LEN + 1)  : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // odd parity: data bits plus parity bit must hold an odd number of ones
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic [FW-1:0] r_fcnt;
  logic          r_filt, r_filt_d;
  state_t        r_state, w_state_nxt;
  logic [2:0]    r_bitcnt, w_bitcnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_par, w_par_nxt;
  logic [TW-1:0] r_to_cnt, w_to_nxt;
  logic          w_fall;
  logic          w_good, w_perr, w_ferr;
  logic [15:0]   r_keycode;
  logic [7:0]    r_rx_byte;
  logic          r_byte_valid, r_parity_err, r_frame_err;

  // two-stage synchronisers for both PS/2 pins (idle-high reset value)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // glitch filter: follow the synchronised clock only after FILTER_LEN stable cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fcnt   <= '0;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_s2 != r_filt) begin
        if (r_fcnt == FW'(FILTER_LEN - 1)) begin
          r_filt <= r_clk_s2;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + FW'(1);
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  assign w_fall = r_filt_d & ~r_filt;

  // FSM state, shift register and timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'd0;
      r_par    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_par    <= w_par_nxt;
      r_to_cnt <= w_to_nxt;
    end
  end

  // next-state logic: a falling edge always wins over timeout expiry
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_par_nxt    = r_par;
    w_to_nxt     = r_to_cnt;
    w_good       = 1'b0;
    w_perr       = 1'b0;
    w_ferr       = 1'b0;
    if (r_state == S_IDLE) begin
      w_to_nxt = '0;
      if (w_fall && !r_dat_s2) begin
        w_state_nxt  = S_DATA;
        w_bitcnt_nxt = 3'd0;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end else if (!w_fall) begin
      if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        w_ferr      = 1'b1;
        w_state_nxt = S_IDLE;
        w_to_nxt    = '0;
      end else begin
        w_to_nxt = r_to_cnt + TW'(1);
      end
    end else begin
      w_to_nxt = '0;
      case (r_state)
        S_DATA: begin
          w_shift_nxt  = {r_dat_s2, r_shift[7:1]};
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            w_state_nxt = S_PARITY;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
        S_PARITY: begin
          w_par_nxt   = r_dat_s2;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          w_perr      = ~parity_ok(r_shift, r_par);
          w_ferr      = ~r_dat_s2;
          w_good      = parity_ok(r_shift, r_par) & r_dat_s2;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // registered result outputs and one-cycle strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_keycode    <= 16'd0;
      r_rx_byte    <= 8'd0;
      r_byte_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= w_good;
      r_parity_err <= w_perr;
      r_frame_err  <= w_ferr;
      if (w_good) begin
        r_rx_byte <= r_shift;
        r_keycode <= {r_keycode[7:0], r_shift};
      end else begin
        r_rx_byte <= r_rx_byte;
        r_keycode <= r_keycode;
      end
    end
  end

  assign keycode    = r_keycode;
  assign rx_byte    = r_rx_byte;
  assign byte_valid = r_byte_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;

`ifdef PS2_RX_ERRCNT_EN
  logic [7:0] r_err_count;

  // saturating count of cycles carrying any error strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if ((r_parity_err || r_frame_err) && (r_err_count != 8'd255)) begin
      r_err_count <= r_err_count + 8'd1;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: directed frames, timeout, glitch,
// mid-frame reset and randomized frames against a frame-level reference model.
module tb_ps2_frame_rx;

  localparam int FILT = 8;
  localparam int TOUT = 500;

  logic        clk;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] keycode;
  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        parity_err;
  logic        frame_err;
  logic [7:0]  err_count;

  ps2_frame_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .rx_byte(rx_byte), .byte_valid(byte_valid),
    .parity_err(parity_err), .frame_err(frame_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  logic [15:0] m_kc  = 16'd0;
  logic [7:0]  m_rx  = 8'd0;
  int          m_err = 0;

  // strobe cycle totals observed by the monitor
  int bv_tot = 0, pe_tot = 0, fe_tot = 0, both_tot = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid) bv_tot = bv_tot + 1;
      if (parity_err) pe_tot = pe_tot + 1;
      if (frame_err) fe_tot = fe_tot + 1;
      if (parity_err && frame_err) both_tot = both_tot + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int hp);
    ps2_data = b;
    wait_clks(hp);
    ps2_clk = 1'b0;
    wait_clks(hp);
    ps2_clk = 1'b1;
  endtask

  function automatic int exp_err_count();
`ifdef PS2_RX_ERRCNT_EN
    return (m_err > 255) ? 255 : m_err;
`else
    return 0;
`endif
  endfunction

  // send one full frame and check the outcome against the model
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pflip,
                           input logic stop, input int hp);
    int bv0, pe0, fe0, bo0;
    logic par;
    logic p_bad;
    logic good;
    bv0 = bv_tot; pe0 = pe_tot; fe0 = fe_tot; bo0 = both_tot;
    par = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
    par = par ^ pflip;
    send_bit(1'b0, hp);
    for (int i = 0; i < 8; i++) send_bit(d[i], hp);
    send_bit(par, hp);
    send_bit(stop, hp);
    ps2_data = 1'b1;
    wait_clks(hp + 20);
    p_bad = (($countones({d, par}) % 2) == 0);
    good  = !p_bad && stop;
    if (good) begin
      m_kc = {m_kc[7:0], d};
      m_rx = d;
    end
    if (p_bad || !stop) m_err++;
    check_eq({tag, "_bv"},   bv_tot - bv0, good ? 1 : 0);
    check_eq({tag, "_pe"},   pe_tot - pe0, p_bad ? 1 : 0);
    check_eq({tag, "_fe"},   fe_tot - fe0, stop ? 0 : 1);
    check_eq({tag, "_both"}, both_tot - bo0, (p_bad && !stop) ? 1 : 0);
    check_eq({tag, "_rx"},   rx_byte, m_rx);
    check_eq({tag, "_kc"},   keycode, m_kc);
    check_eq({tag, "_ec"},   err_count, exp_err_count());
  endtask

  initial begin
    int bv0, pe0, fe0;
    int k;
    logic [7:0] rb;
    logic [1:0] mode;
    logic [7:0] pd;
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_clks(5);
    #1;
    check_eq("rst_kc", keycode, 16'd0);
    check_eq("rst_rx", rx_byte, 8'd0);
    check_eq("rst_bv", byte_valid, 1'b0);
    check_eq("rst_pe", parity_err, 1'b0);
    check_eq("rst_fe", frame_err, 1'b0);
    check_eq("rst_ec", err_count, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_clks(20);

    // basic frames
    run_frame("t1_1c", 8'h1C, 1'b0, 1'b1, 20);
    run_frame("t2_f0", 8'hF0, 1'b0, 1'b1, 20);
    run_frame("t2_1c", 8'h1C, 1'b0, 1'b1, 20);
    check_eq("t2_kcfin", keycode, 16'hF01C);
    run_frame("t3_par", 8'h29, 1'b1, 1'b1, 20);
    run_frame("t3_stop", 8'h29, 1'b0, 1'b0, 20);
    run_frame("t3_both", 8'h29, 1'b1, 1'b0, 20);

    // timeout: start plus 4 data bits, then the clock stays high
    bv0 = bv_tot; pe0 = pe_tot; fe0 = fe_tot;
    pd = 8'h5A;
    send_bit(1'b0, 20);
    for (int i = 0; i < 3; i++) send_bit(pd[i], 20);
    ps2_data = pd[3];
    wait_clks(20);
    ps2_clk = 1'b0;
    k = 0;
    while (k < 700) begin
      @(negedge clk);
      #1;
      k++;
      if (k == 20) ps2_clk = 1'b1;
      if (frame_err) break;
    end
    m_err++;
    check_eq("to_win", (k >= TOUT + 5 && k <= TOUT + 15) ? 1 : 0, 1);
    wait_clks(20);
    check_eq("to_fe", fe_tot - fe0, 1);
    check_eq("to_bv", bv_tot - bv0, 0);
    check_eq("to_pe", pe_tot - pe0, 0);
    check_eq("to_ec", err_count, exp_err_count());
    run_frame("to_5a", 8'h5A, 1'b0, 1'b1, 20);
    check_eq("to_kclo", keycode[7:0], 8'h5A);

    // glitch shorter than the filter window while idle
    bv0 = bv_tot; pe0 = pe_tot; fe0 = fe_tot;
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    wait_clks(FILT - 2);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_clks(40);
    check_eq("gl_bv", bv_tot - bv0, 0);
    check_eq("gl_pe", pe_tot - pe0, 0);
    check_eq("gl_fe", fe_tot - fe0, 0);
    run_frame("gl_1c", 8'h1C, 1'b0, 1'b1, 20);

    // randomized frames
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom_range(0, 255));
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) mode = 2'd0;
      run_frame("rnd", rb, mode[0], ~mode[1], $urandom_range(12, 30));
    end

    // reset after the 6th data bit of 0x1C
    pd = 8'h1C;
    bv0 = bv_tot; pe0 = pe_tot; fe0 = fe_tot;
    send_bit(1'b0, 20);
    for (int i = 0; i < 6; i++) send_bit(pd[i], 20);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mr_kc", keycode, 16'd0);
    check_eq("mr_rx", rx_byte, 8'd0);
    check_eq("mr_bv", byte_valid, 1'b0);
    check_eq("mr_pe", parity_err, 1'b0);
    check_eq("mr_fe", frame_err, 1'b0);
    check_eq("mr_ec", err_count, 8'd0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    m_kc = 16'd0;
    m_rx = 8'd0;
    m_err = 0;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(20);
    check_eq("mr_nostb", (bv_tot - bv0) + (pe_tot - pe0) + (fe_tot - fe0), 0);
    run_frame("mr_23", 8'h23, 1'b0, 1'b1, 20);
    check_eq("mr_kcfin", keycode, 16'h0023);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
